parking_lot_ctrl: RTL and testbench
===================================

PARKING_LOT_CTRL -- requirements
Module: parking_lot_ctrl

Interface
REQ-001 SHALL have parameter CAPACITY, default 7: maximum number of cars held.
REQ-002 SHALL have parameter CNT_W, default 3: count width; CAPACITY <= 2^CNT_W - 1.
REQ-003 SHALL have parameter DEBOUNCE_CYC, default 4: filter length in cycles; used only with PKLOT_DEBOUNCE_EN.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port sensor_a  input  1: outer beam; 1 = blocked.
REQ-007 SHALL have port sensor_b  input  1: inner beam; 1 = blocked.
REQ-008 SHALL have port count  output  CNT_W: registered number of cars inside.
REQ-009 SHALL have port full  output  1: high when count == CAPACITY.
REQ-010 SHALL have port empty  output  1: high when count == 0.
REQ-011 SHALL have port car_in  output  1: one-cycle pulse on an accepted entry.
REQ-012 SHALL have port car_out  output  1: one-cycle pulse on an accepted exit.
REQ-013 SHALL have port err  output  1: one-cycle pulse on an illegal sensor sequence, overflow or underflow.

Function
REQ-014 SHALL have FSM input s = {a_f, b_f}: the filtered sensors (REQ-030/031).
REQ-015 SHALL have seven FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3.
REQ-016 SHALL make these IDLE transitions: s=10 -> EN1; s=01 -> EX1; s=00 -> stay; s=11 -> stay and pulse err.
REQ-017 SHALL make these EN1 transitions: 10 -> stay; 11 -> EN2; 00 -> IDLE (silent abort); 01 -> IDLE and pulse err.
REQ-018 SHALL make these EN2 transitions: 11 -> stay; 01 -> EN3; 10 -> EN1 (backing out); 00 -> IDLE and pulse err.
REQ-019 SHALL make these EN3 transitions: 01 -> stay; 11 -> EN2; 10 -> IDLE and pulse err; 00 -> IDLE and complete the entry.
REQ-020 SHALL mirror EN1-EN3 in EX1-EX3 with a and b swapped; completion is s=00 from EX3 (exit sequence 01,11,10,00).
REQ-021 SHALL update count and assert car_in/car_out on the same clock edge that moves the FSM to IDLE on completion: latency 1 cycle from s=00 being present.
REQ-022 SHALL, on entry completion with count == CAPACITY, hold count, suppress car_in and pulse err.
REQ-023 SHALL, on exit completion with count == 0, hold count, suppress car_out and pulse err.
REQ-024 SHALL never wrap count: count stays in range 0..CAPACITY.
REQ-025 SHALL hold car_in, car_out and err high for exactly one cycle per event; at most one of car_in/car_out per cycle.
REQ-026 SHALL decode full and empty combinationally from the count register.

Reset
REQ-027 SHALL, while reset is high at a clock edge, set: FSM = IDLE; count = 0; car_in = car_out = err = 0; empty = 1; full = 0.
REQ-028 SHALL, when reset occurs mid-sequence, discard the partial sequence without a count change or pulse.
REQ-029 SHALL, with PKLOT_DEBOUNCE_EN, also clear synchronisers, filter counters and a_f/b_f to 0 on reset.

Configuration
REQ-030 SHALL, with PKLOT_DEBOUNCE_EN defined:
- pass each sensor through a 2-flop synchroniser, then a filter;
- the filter updates a_f/b_f only after the synchronised value differs from it for DEBOUNCE_CYC consecutive cycles;
- input-to-filtered latency = 2 + DEBOUNCE_CYC cycles;
- shorter glitches are ignored.
REQ-031 SHALL, with PKLOT_DEBOUNCE_EN undefined, set a_f = sensor_a and b_f = sensor_b directly, add no latency, and leave DEBOUNCE_CYC unused.

Verification
REQ-032 SHALL cover this entry: reset 2 cycles, then s = 10,11,01,00 held 2 cycles each -> count 0->1, one car_in pulse, empty falls.
REQ-033 SHALL cover this exit: from count=1, s = 01,11,10,00 -> count 1->0, one car_out pulse, empty rises.
REQ-034 SHALL cover overflow: 8 entries at CAPACITY=7 -> count stays 7, full=1, 8th entry gives err pulse and no car_in.
REQ-035 SHALL cover abort and illegal sequences:
- 10,00 -> no change, no err;
- 10,01 -> err pulse, count unchanged;
- 11 from IDLE -> err pulse.
REQ-036 SHALL cover reset mid-sequence: reset asserted in EN2 -> count 0, no pulses; a following full entry counts normally.
REQ-037 SHALL cover debounce (PKLOT_DEBOUNCE_EN): a 2-cycle sensor_a glitch -> no state change; an entry with phases held 8 cycles counts 1 with latency 2+DEBOUNCE_CYC.

Source files
------------

// File: rtl/parking_lot_ctrl.sv
// Parking lot entry/exit controller.
// Two light beams (outer sensor_a, inner sensor_b) are tracked through the
// full blocking sequence before a car is counted in or out. Aborted passages
// are dropped silently. Impossible beam patterns, and entries into a full lot
// or exits from an empty lot, raise a one-cycle err pulse.
//
// Optional feature macro: PKLOT_DEBOUNCE_EN
//   defined   : each sensor passes through a 2-flop synchroniser and a
//               DEBOUNCE_CYC-cycle persistence filter (latency 2 + DEBOUNCE_CYC)
//   undefined : sensors drive the FSM directly, DEBOUNCE_CYC has no effect

module parking_lot_ctrl #(
  parameter int unsigned CAPACITY     = 7,
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_a,
  input  logic             sensor_b,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             car_in,
  output logic             car_out,
  output logic             err
);

  // Reject configurations that cannot work at elaboration time.
  if (CAPACITY > (2 ** CNT_W) - 1) begin : g_bad_capacity
    $error("CAPACITY does not fit in CNT_W bits");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be at least 1");
  end

  localparam logic [CNT_W-1:0] CapCnt = CNT_W'(CAPACITY);

  // Filtered sensor pair seen by the FSM: {a_f, b_f}.
  logic [1:0] s;

`ifdef PKLOT_DEBOUNCE_EN
  localparam int unsigned DebW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]      sync1_q;
  logic [1:0]      sync2_q;
  logic [1:0]      filt_q;
  logic [DebW-1:0] deb_cnt_q [2];

  // Synchronise both beams, then only accept a new level once it has
  // persisted for DEBOUNCE_CYC consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      filt_q  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= {sensor_a, sensor_b};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (deb_cnt_q[i] == DebW'(DEBOUNCE_CYC - 1)) begin
            filt_q[i]    <= sync2_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + DebW'(1);
          end
        end else begin
          // Any return to the accepted level restarts the persistence window.
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign s = filt_q;
`else
  assign s = {sensor_a, sensor_b};
`endif

  typedef enum logic [2:0] {
    StIdle,
    StEn1,
    StEn2,
    StEn3,
    StEx1,
    StEx2,
    StEx3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic             car_in_q;
  logic             car_out_q;
  logic             err_q;

  // Passage tracking FSM with registered count and event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      car_in_q  <= 1'b0;
      car_out_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      car_in_q  <= 1'b0;
      car_out_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          case (s)
            2'b10:   state_q <= StEn1;
            2'b01:   state_q <= StEx1;
            2'b11:   err_q   <= 1'b1;  // both beams broken with no lead-in
            default: state_q <= StIdle;
          endcase
        end
        // Entry: a, a+b, b, clear.
        StEn1: begin
          case (s)
            2'b10:   state_q <= StEn1;
            2'b11:   state_q <= StEn2;
            2'b01: begin
              state_q <= StIdle;
              err_q   <= 1'b1;
            end
            default: state_q <= StIdle;  // car backed away before reaching b
          endcase
        end
        StEn2: begin
          case (s)
            2'b11:   state_q <= StEn2;
            2'b01:   state_q <= StEn3;
            2'b10:   state_q <= StEn1;
            default: begin
              state_q <= StIdle;
              err_q   <= 1'b1;
            end
          endcase
        end
        StEn3: begin
          case (s)
            2'b01:   state_q <= StEn3;
            2'b11:   state_q <= StEn2;
            2'b10: begin
              state_q <= StIdle;
              err_q   <= 1'b1;
            end
            default: begin
              state_q <= StIdle;
              if (count_q == CapCnt) begin
                err_q <= 1'b1;
              end else begin
                count_q  <= count_q + CNT_W'(1);
                car_in_q <= 1'b1;
              end
            end
          endcase
        end
        // Exit: b, a+b, a, clear.
        StEx1: begin
          case (s)
            2'b01:   state_q <= StEx1;
            2'b11:   state_q <= StEx2;
            2'b10: begin
              state_q <= StIdle;
              err_q   <= 1'b1;
            end
            default: state_q <= StIdle;
          endcase
        end
        StEx2: begin
          case (s)
            2'b11:   state_q <= StEx2;
            2'b10:   state_q <= StEx3;
            2'b01:   state_q <= StEx1;
            default: begin
              state_q <= StIdle;
              err_q   <= 1'b1;
            end
          endcase
        end
        StEx3: begin
          case (s)
            2'b10:   state_q <= StEx3;
            2'b11:   state_q <= StEx2;
            2'b01: begin
              state_q <= StIdle;
              err_q   <= 1'b1;
            end
            default: begin
              state_q <= StIdle;
              if (count_q == '0) begin
                err_q <= 1'b1;
              end else begin
                count_q   <= count_q - CNT_W'(1);
                car_out_q <= 1'b1;
              end
            end
          endcase
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign count   = count_q;
  assign car_in  = car_in_q;
  assign car_out = car_out_q;
  assign err     = err_q;
  assign full    = (count_q == CapCnt);
  assign empty   = (count_q == '0);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Bench for parking_lot_ctrl: directed scenarios plus random passages, all
// checked every cycle against a path-walking reference model. When
// PKLOT_DEBOUNCE_EN is defined the model sees the inputs through a pure
// delay line of 2 + DEBOUNCE_CYC cycles and every level is held long enough
// to pass the filter.

module tb_parking_lot_ctrl;

  localparam int unsigned CAP = 7;
  localparam int unsigned CW  = 3;
  localparam int unsigned DEB = 4;
`ifdef PKLOT_DEBOUNCE_EN
  localparam int LAT  = 2 + DEB;
  localparam int MINH = DEB;
`else
  localparam int LAT  = 0;
  localparam int MINH = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          sensor_a;
  logic          sensor_b;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          car_in;
  logic          car_out;
  logic          err;

  parking_lot_ctrl #(
    .CAPACITY    (CAP),
    .CNT_W       (CW),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sensor_a(sensor_a),
    .sensor_b(sensor_b),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .car_in  (car_in),
    .car_out (car_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: direction (0 none, 1 entry, 2 exit), position along the
  // expected beam pattern, and number of cars.
  int         m_dir;
  int         m_k;
  int         m_count;
  logic       m_in;
  logic       m_out;
  logic       m_err;
  logic [1:0] hist [$];

  int n_in;
  int n_out;
  int n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One filtered sample applied to the model. A passage is a walk along
  // 00,10,11,01,00 (entry) or its bit-swapped twin (exit): staying, stepping
  // forward or stepping back one place is legal; anything else is an error.
  task automatic model_step(input logic [1:0] fs);
    logic [1:0] p [0:4];
    m_in  = 1'b0;
    m_out = 1'b0;
    m_err = 1'b0;
    if (m_dir == 0) begin
      if (fs == 2'b10) begin
        m_dir = 1;
        m_k   = 1;
      end else if (fs == 2'b01) begin
        m_dir = 2;
        m_k   = 1;
      end else if (fs == 2'b11) begin
        m_err = 1'b1;
      end
    end else begin
      p = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
      if (m_dir == 2) begin
        for (int i = 0; i < 5; i++) p[i] = {p[i][0], p[i][1]};
      end
      if (fs != p[m_k]) begin
        if (fs == p[m_k + 1]) begin
          if (m_k == 3) begin
            if (m_dir == 1) begin
              if (m_count == CAP) m_err = 1'b1;
              else begin
                m_count++;
                m_in = 1'b1;
              end
            end else begin
              if (m_count == 0) m_err = 1'b1;
              else begin
                m_count--;
                m_out = 1'b1;
              end
            end
            m_dir = 0;
          end else begin
            m_k++;
          end
        end else if (fs == p[m_k - 1]) begin
          m_k--;
          if (m_k == 0) m_dir = 0;
        end else begin
          m_err = 1'b1;
          m_dir = 0;
        end
      end
    end
  endtask

  // Drive raw inputs for one cycle; the model is fed mdl (normally == raw).
  task automatic cycle(input logic [1:0] raw, input logic [1:0] mdl);
    logic [1:0] fs;
    sensor_a = raw[1];
    sensor_b = raw[0];
    hist.push_back(mdl);
    fs = hist.pop_front();
    model_step(fs);
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(m_count));
    check("full", 32'(full), 32'(m_count == CAP));
    check("empty", 32'(empty), 32'(m_count == 0));
    check("car_in", 32'(car_in), 32'(m_in));
    check("car_out", 32'(car_out), 32'(m_out));
    check("err", 32'(err), 32'(m_err));
    if (car_in === 1'b1) n_in++;
    if (car_out === 1'b1) n_out++;
    if (err === 1'b1) n_err++;
  endtask

  task automatic run(input logic [1:0] v, input int n);
    repeat (n) cycle(v, v);
  endtask

  task automatic hold(input logic [1:0] v);
    run(v, MINH + int'($urandom_range(0, 1)));
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_pulses", {29'd0, car_in, car_out, err}, 0);
    end
    reset   = 1'b0;
    m_dir   = 0;
    m_k     = 0;
    m_count = 0;
    hist    = {};
    for (int i = 0; i < LAT; i++) hist.push_back(2'b00);
  endtask

  task automatic entry();
    hold(2'b10);
    hold(2'b11);
    hold(2'b01);
    hold(2'b00);
    run(2'b00, LAT);
  endtask

  task automatic leave();
    hold(2'b01);
    hold(2'b11);
    hold(2'b10);
    hold(2'b00);
    run(2'b00, LAT);
  endtask

  initial begin
    int         b_in;
    int         b_out;
    int         b_err;
    int         op;
    logic [1:0] seq [0:3];
    n_in  = 0;
    n_out = 0;
    n_err = 0;
    do_reset(2);

    // Basic entry then exit.
    b_in = n_in;
    entry();
    check("entry_pulses", 32'(n_in - b_in), 1);
    check("entry_count", 32'(count), 1);
    check("entry_empty", 32'(empty), 0);
    b_out = n_out;
    leave();
    check("exit_pulses", 32'(n_out - b_out), 1);
    check("exit_count", 32'(count), 0);
    check("exit_empty", 32'(empty), 1);

    // Exit from an empty lot.
    b_out = n_out;
    b_err = n_err;
    leave();
    check("underflow_err", 32'(n_err - b_err), 1);
    check("underflow_out", 32'(n_out - b_out), 0);
    check("underflow_count", 32'(count), 0);

    // Eight entries into a lot of seven.
    b_in  = n_in;
    b_err = n_err;
    repeat (8) entry();
    check("overflow_count", 32'(count), CAP);
    check("overflow_full", 32'(full), 1);
    check("overflow_in", 32'(n_in - b_in), CAP);
    check("overflow_err", 32'(n_err - b_err), 1);

    // Silent abort, then 10 followed by 01, then both beams from idle.
    b_err = n_err;
    hold(2'b10);
    hold(2'b00);
    run(2'b00, LAT + 1);
    check("abort_err", 32'(n_err - b_err), 0);
    check("abort_count", 32'(count), CAP);
    b_err = n_err;
    hold(2'b10);
    hold(2'b01);
    hold(2'b00);
    run(2'b00, LAT + 1);
    check("illegal_err", 32'(n_err - b_err), 1);
    check("illegal_count", 32'(count), CAP);
    b_err = n_err;
    run(2'b11, MINH);
    run(2'b00, LAT + 1);
    check("idle11_err", 32'(n_err - b_err), MINH);

    // Reset while the entry is in its middle phase.
    hold(2'b10);
    run(2'b11, LAT + 2);
    b_in  = n_in;
    b_err = n_err;
    do_reset(1);
    run(2'b00, LAT + 1);
    check("midrst_count", 32'(count), 0);
    check("midrst_pulses", 32'(n_in - b_in + n_err - b_err), 0);
    entry();
    check("midrst_entry", 32'(count), 1);

`ifdef PKLOT_DEBOUNCE_EN
    // A short glitch on the outer beam must not reach the FSM.
    b_err = n_err;
    cycle(2'b10, 2'b00);
    cycle(2'b10, 2'b00);
    run(2'b00, LAT + 2);
    check("glitch_err", 32'(n_err - b_err), 0);
    check("glitch_count", 32'(count), 1);
    // Slow entry, each phase held 8 cycles.
    run(2'b10, 8);
    run(2'b11, 8);
    run(2'b01, 8);
    run(2'b00, 8);
    check("slow_entry", 32'(count), 2);
`endif

    // Random passages, partly corrupted, with occasional resets.
    for (int it = 0; it < 200; it++) begin
      op = int'($urandom_range(0, 19));
      if (op < 8 || (op >= 8 && op < 15)) begin
        if (op < 8) seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        else        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        for (int j = 0; j < 4; j++) begin
          if ($urandom_range(0, 7) == 0) hold(2'($urandom_range(0, 3)));
          else hold(seq[j]);
        end
      end else if (op < 19) begin
        hold(2'($urandom_range(0, 3)));
      end else begin
        do_reset(1);
      end
    end
    run(2'b00, LAT + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
